// File: rtl/move_input_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : move_input_ctrl
// Description : Button front end for the frogger game. Synchronizes and
//               debounces five raw buttons, turns Start into a one-cycle
//               game-start pulse and turns the four directions into
//               one-cycle move pulses with hold-to-repeat behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module move_input_ctrl #(
  parameter int c_DEBOUNCE_LIMIT = 250000,
  parameter int c_REPEAT_DELAY   = 12500000,
  parameter int c_REPEAT_PERIOD  = 5000000
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Up_Btn,
  input  logic       i_Down_Btn,
  input  logic       i_Left_Btn,
  input  logic       i_Right_Btn,
  input  logic       i_Start_Btn,
  input  logic       i_Move_Enable,
  output logic       o_Up_Mvt,
  output logic       o_Down_Mvt,
  output logic       o_Left_Mvt,
  output logic       o_Right_Mvt,
  output logic       o_Game_Start,
  output logic [4:0] o_Btn_State
);

  // Counter widths; guarded so a limit of 1 still yields a 1-bit counter.
  localparam int c_DB_W    = (c_DEBOUNCE_LIMIT > 1) ? $clog2(c_DEBOUNCE_LIMIT) : 1;
  localparam int c_RPT_MAX = (c_REPEAT_DELAY > c_REPEAT_PERIOD) ? c_REPEAT_DELAY
                                                                 : c_REPEAT_PERIOD;
  localparam int c_RPT_W   = (c_RPT_MAX > 1) ? $clog2(c_RPT_MAX) : 1;

  localparam logic [c_DB_W-1:0]  c_DB_TOP  = c_DB_W'(c_DEBOUNCE_LIMIT - 1);
  localparam logic [c_DB_W-1:0]  c_DB_ONE  = c_DB_W'(1);
  localparam logic [c_RPT_W-1:0] c_DLY_TOP = c_RPT_W'(c_REPEAT_DELAY - 1);
  localparam logic [c_RPT_W-1:0] c_PER_TOP = c_RPT_W'(c_REPEAT_PERIOD - 1);
  localparam logic [c_RPT_W-1:0] c_RPT_ONE = c_RPT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DELAY  = 2'd1,
    S_REPEAT = 2'd2
  } t_rpt_state;

  // Button vector order: {Start, Right, Left, Down, Up}, bit 0 = Up.
  logic [4:0] w_Raw;
  logic [4:0] r_Sync1;
  logic [4:0] r_Sync2;
  logic [4:0] w_Db;
  logic [4:0] r_Db_Prev;
  logic [3:0] w_Rise;

  logic               r_Game_Start;
  logic [3:0]         r_Mvt;
  t_rpt_state         r_State;
  t_rpt_state         w_State_Next;
  logic [1:0]         r_Dir;
  logic [1:0]         w_Dir_Next;
  logic [c_RPT_W-1:0] r_Rpt_Cnt;
  logic [c_RPT_W-1:0] w_Cnt_Next;
  logic [3:0]         w_Mvt_Next;
  logic [3:0]         w_Dir_Oh;
  logic               w_Dir_Held;
  logic [3:0]         w_Cand;
  logic               w_Win_Valid;
  logic [1:0]         w_Win_Dir;

  assign w_Raw = {i_Start_Btn, i_Right_Btn, i_Left_Btn, i_Down_Btn, i_Up_Btn};

  // Two-flop synchronizer for every raw button.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      r_Sync1 <= '0;
      r_Sync2 <= '0;
    end else begin
      r_Sync1 <= w_Raw;
      r_Sync2 <= r_Sync1;
    end
  end

  generate
    for (genvar g = 0; g < 5; g++) begin : g_debounce
      logic [c_DB_W-1:0] r_Cnt;
      logic              r_Level;

      // Accept a new level only after it has been seen for the full limit.
      always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
          r_Cnt   <= '0;
          r_Level <= 1'b0;
        end else if (r_Sync2[g] == r_Level) begin
          r_Cnt   <= '0;
        end else if (r_Cnt == c_DB_TOP) begin
          r_Cnt   <= '0;
          r_Level <= ~r_Level;
        end else begin
          r_Cnt   <= r_Cnt + c_DB_ONE;
        end
      end

      assign w_Db[g] = r_Level;
    end
  endgenerate

  assign w_Rise     = w_Db[3:0] & ~r_Db_Prev[3:0];
  assign w_Dir_Oh   = 4'b0001 << r_Dir;
  assign w_Dir_Held = |(w_Db[3:0] & w_Dir_Oh);

  // Edge history and start pulse; start ignores the move enable.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      r_Db_Prev    <= '0;
      r_Game_Start <= 1'b0;
    end else begin
      r_Db_Prev    <= w_Db;
      r_Game_Start <= w_Db[4] & ~r_Db_Prev[4];
    end
  end

  // Pick the winning new press: Up > Down > Left > Right; the tracked direction is excluded while active.
  always_comb begin
    w_Cand = w_Rise;
    if (r_State != S_IDLE) begin
      w_Cand = w_Rise & ~w_Dir_Oh;
    end
    w_Win_Valid = |w_Cand;
    w_Win_Dir   = 2'd0;
    if (w_Cand[0]) begin
      w_Win_Dir = 2'd0;
    end else if (w_Cand[1]) begin
      w_Win_Dir = 2'd1;
    end else if (w_Cand[2]) begin
      w_Win_Dir = 2'd2;
    end else if (w_Cand[3]) begin
      w_Win_Dir = 2'd3;
    end
  end

  // Repeat FSM next-state, next direction, repeat counter and move pulse.
  always_comb begin
    w_State_Next = r_State;
    w_Dir_Next   = r_Dir;
    w_Cnt_Next   = r_Rpt_Cnt;
    w_Mvt_Next   = 4'b0000;
    if (!i_Move_Enable) begin
      w_State_Next = S_IDLE;
      w_Cnt_Next   = '0;
    end else begin
      case (r_State)
        S_IDLE: begin
          w_Cnt_Next = '0;
          if (w_Win_Valid) begin
            w_Mvt_Next   = 4'b0001 << w_Win_Dir;
            w_Dir_Next   = w_Win_Dir;
            w_State_Next = S_DELAY;
          end
        end
        S_DELAY, S_REPEAT: begin
          if (w_Win_Valid) begin
            w_Mvt_Next   = 4'b0001 << w_Win_Dir;
            w_Dir_Next   = w_Win_Dir;
            w_Cnt_Next   = '0;
            w_State_Next = S_DELAY;
          end else if (!w_Dir_Held) begin
            w_Cnt_Next   = '0;
            w_State_Next = S_IDLE;
          end else if (r_Rpt_Cnt == ((r_State == S_DELAY) ? c_DLY_TOP : c_PER_TOP)) begin
            w_Mvt_Next   = w_Dir_Oh;
            w_Cnt_Next   = '0;
            w_State_Next = S_REPEAT;
          end else begin
            w_Cnt_Next   = r_Rpt_Cnt + c_RPT_ONE;
          end
        end
        default: begin
          w_Cnt_Next   = '0;
          w_State_Next = S_IDLE;
        end
      endcase
    end
  end

  // Repeat FSM state, tracked direction, counter and registered move pulses.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      r_State   <= S_IDLE;
      r_Dir     <= 2'd0;
      r_Rpt_Cnt <= '0;
      r_Mvt     <= 4'b0000;
    end else begin
      r_State   <= w_State_Next;
      r_Dir     <= w_Dir_Next;
      r_Rpt_Cnt <= w_Cnt_Next;
      r_Mvt     <= w_Mvt_Next;
    end
  end

  assign o_Up_Mvt     = r_Mvt[0];
  assign o_Down_Mvt   = r_Mvt[1];
  assign o_Left_Mvt   = r_Mvt[2];
  assign o_Right_Mvt  = r_Mvt[3];
  assign o_Game_Start = r_Game_Start;
  assign o_Btn_State  = w_Db;

endmodule
`default_nettype wire

// File: tb/tb_move_input_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_move_input_ctrl
// Description : Self-checking bench for move_input_ctrl (limits 4 / 10 / 6).
//               A schedule-based reference model is compared every cycle;
//               directed scenarios pin pulse timing with literal masks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_move_input_ctrl;

  localparam int c_DB  = 4;
  localparam int c_DLY = 10;
  localparam int c_PER = 6;

  logic       clk = 1'b0;
  logic       rst_l = 1'b0;
  logic       up_b = 1'b0, down_b = 1'b0, left_b = 1'b0, right_b = 1'b0, start_b = 1'b0;
  logic       en = 1'b0;
  logic       o_up, o_down, o_left, o_right, o_start;
  logic [4:0] o_btn;

  int n_assert = 0;
  int n_fail   = 0;

  logic [9:0] hist[$];

  move_input_ctrl #(
    .c_DEBOUNCE_LIMIT(c_DB),
    .c_REPEAT_DELAY  (c_DLY),
    .c_REPEAT_PERIOD (c_PER)
  ) dut (
    .i_Clk        (clk),
    .i_Rst_L      (rst_l),
    .i_Up_Btn     (up_b),
    .i_Down_Btn   (down_b),
    .i_Left_Btn   (left_b),
    .i_Right_Btn  (right_b),
    .i_Start_Btn  (start_b),
    .i_Move_Enable(en),
    .o_Up_Mvt     (o_up),
    .o_Down_Mvt   (o_down),
    .o_Left_Mvt   (o_left),
    .o_Right_Mvt  (o_right),
    .o_Game_Start (o_start),
    .o_Btn_State  (o_btn)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int         m_cyc = 0;
  bit         m_valid = 0;
  logic [4:0] m_s1 = '0, m_s2 = '0, m_db = '0, m_prev = '0;
  int         m_run[5] = '{0, 0, 0, 0, 0};
  int         m_dir = -1;
  int         m_next = 0;
  logic [3:0] m_mvt = '0;
  logic       m_start = 1'b0;

  task automatic model_edge();
    logic [3:0] rise;
    logic [3:0] nm;
    logic [4:0] raw;
    int w;
    raw = {start_b, right_b, left_b, down_b, up_b};
    if (!rst_l) begin
      m_s1 = '0; m_s2 = '0; m_db = '0; m_prev = '0;
      for (int b = 0; b < 5; b++) m_run[b] = 0;
      m_dir = -1; m_mvt = '0; m_start = 1'b0; m_valid = 1;
    end else begin
      rise = m_db[3:0] & ~m_prev[3:0];
      nm = '0;
      if (!en) begin
        m_dir = -1;
      end else begin
        if (m_dir >= 0) rise[m_dir] = 1'b0;
        w = -1;
        for (int b = 3; b >= 0; b--) if (rise[b]) w = b;
        if (w >= 0) begin
          nm[w] = 1'b1; m_dir = w; m_next = m_cyc + c_DLY;
        end else if (m_dir >= 0 && !m_db[m_dir]) begin
          m_dir = -1;
        end else if (m_dir >= 0 && m_cyc == m_next) begin
          nm[m_dir] = 1'b1; m_next = m_cyc + c_PER;
        end
      end
      m_start = m_db[4] & ~m_prev[4];
      m_prev = m_db;
      for (int b = 0; b < 5; b++) begin
        if (m_s2[b] != m_db[b]) begin
          m_run[b]++;
          if (m_run[b] == c_DB) begin
            m_db[b] = ~m_db[b];
            m_run[b] = 0;
          end
        end else begin
          m_run[b] = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = raw;
      m_mvt = nm;
    end
    m_cyc++;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_edge();
    end
  end

  // Cycle-by-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (m_valid) begin
        n_assert++;
        if ({o_btn, o_start, o_right, o_left, o_down, o_up} !== {m_db, m_start, m_mvt}) begin
          n_fail++;
          $display("FAIL model_compare cyc=%0d: got btn=%b start=%b mvt=%b, expected btn=%b start=%b mvt=%b",
                   m_cyc, o_btn, o_start, {o_right, o_left, o_down, o_up}, m_db, m_start, m_mvt);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input logic [4:0] btn, input logic e, input logic r);
    {start_b, right_b, left_b, down_b, up_b} = btn;
    en    = e;
    rst_l = r;
    @(posedge clk);
    #1;
    hist.push_back({o_btn, o_start, o_right, o_left, o_down, o_up});
  endtask

  task automatic hold(input logic [4:0] btn, input logic e, input int n);
    for (int i = 0; i < n; i++) step(btn, e, 1'b1);
  endtask

  task automatic do_reset();
    step(5'b0, 1'b1, 1'b0);
    step(5'b0, 1'b1, 1'b0);
    hist.delete();
  endtask

  // Bit k set when history bit b was high after edge k+1 of the scenario.
  function automatic logic [63:0] pulse_mask(input int b);
    logic [63:0] m;
    m = '0;
    for (int k = 0; k < hist.size() && k < 64; k++) if (hist[k][b]) m[k] = 1'b1;
    return m;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int hold_left[5];
    logic [4:0] btn;
    logic e;
    int en_left;

    do_reset();
    check("reset_outputs", 64'({o_btn, o_start, o_right, o_left, o_down, o_up}), 64'h0);

    // Short Up press: filtered out.
    hold(5'b00001, 1'b1, 3);
    hold(5'b00000, 1'b1, 17);
    check("short_press_up", pulse_mask(0), 64'h0);

    // Up held 20: pulse at edge 7, repeats at 17 and 23 before release settles.
    do_reset();
    hold(5'b00001, 1'b1, 20);
    hold(5'b00000, 1'b1, 12);
    check("clean_press_up", pulse_mask(0), 64'h0000_0000_0041_0040);
    check("clean_press_btnstate", 64'(hist[6][5]), 64'h1);

    // Bouncing Up: single pulse 7 edges after the last bounce.
    do_reset();
    step(5'b00001, 1'b1, 1'b1);
    step(5'b00000, 1'b1, 1'b1);
    step(5'b00001, 1'b1, 1'b1);
    step(5'b00000, 1'b1, 1'b1);
    hold(5'b00001, 1'b1, 10);
    hold(5'b00000, 1'b1, 16);
    check("bounce_up", pulse_mask(0), 64'h0000_0000_0000_0400);

    // Left held: first pulse, then +10, +16, +22, +28, +34; nothing after release.
    do_reset();
    hold(5'b00100, 1'b1, 38);
    hold(5'b00000, 1'b1, 22);
    check("repeat_left", pulse_mask(2), 64'h0000_0104_1041_0040);
    check("repeat_others", pulse_mask(0) | pulse_mask(1) | pulse_mask(3), 64'h0);

    // Up and Right together: Up wins, Right only after re-press.
    do_reset();
    hold(5'b01001, 1'b1, 8);
    hold(5'b01000, 1'b1, 22);
    hold(5'b00000, 1'b1, 10);
    hold(5'b01000, 1'b1, 10);
    hold(5'b00000, 1'b1, 13);
    check("prio_up", pulse_mask(0), 64'h0000_0000_0000_0040);
    check("prio_right", pulse_mask(3), 64'h0000_4000_0000_0000);

    // Start with enable low; Down held while enable rises.
    do_reset();
    hold(5'b10010, 1'b0, 19);
    hold(5'b10010, 1'b1, 21);
    hold(5'b00000, 1'b1, 10);
    check("start_pulse", pulse_mask(4), 64'h0000_0000_0000_0040);
    check("start_no_dir", pulse_mask(0) | pulse_mask(1) | pulse_mask(2) | pulse_mask(3), 64'h0);

    // Reset during REPEAT with Left held throughout.
    do_reset();
    hold(5'b00100, 1'b1, 24);
    step(5'b00100, 1'b1, 1'b0);
    hold(5'b00100, 1'b1, 27);
    check("reset_mid_left", pulse_mask(2), 64'h0000_8200_8041_0040);
    check("reset_mid_zero", 64'(hist[24]), 64'h0);

    // Randomized traffic checked by the model process.
    do_reset();
    for (int b = 0; b < 5; b++) hold_left[b] = 0;
    btn = '0;
    e = 1'b1;
    en_left = 50;
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < 5; b++) begin
        if (hold_left[b] == 0) begin
          btn[b] = ($urandom_range(0, 2) == 0) ? ~btn[b] : btn[b];
          hold_left[b] = (int'($urandom_range(0, 3)) == 0) ? int'($urandom_range(1, 4))
                                                            : int'($urandom_range(5, 40));
        end else begin
          hold_left[b]--;
        end
      end
      if (en_left == 0) begin
        e = ($urandom_range(0, 7) == 0) ? 1'b0 : 1'b1;
        en_left = int'($urandom_range(3, 60));
      end else begin
        en_left--;
      end
      step(btn, e, ($urandom_range(0, 599) == 0) ? 1'b0 : 1'b1);
    end
    hist.delete();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/move_input_ctrl.md
MOVE_INPUT_CTRL -- requirements
Module: move_input_ctrl

Interface
REQ-001 The block SHALL expose parameter c_DEBOUNCE_LIMIT, default 250000, meaning consecutive differing cycles before a debounced button changes state.
REQ-002 The block SHALL expose parameter c_REPEAT_DELAY, default 12500000, meaning cycles a direction is held before the first auto-repeat.
REQ-003 The block SHALL expose parameter c_REPEAT_PERIOD, default 5000000, meaning cycles between subsequent auto-repeats.
REQ-004 i_Clk  input  1  the single system clock (25 MHz pixel clock); all logic on its rising edge.
REQ-005 i_Rst_L  input  1  reset, synchronous and active-low.
REQ-006 i_Up_Btn, i_Down_Btn, i_Left_Btn, i_Right_Btn  input  1 each  raw, asynchronous, active-high, bouncing direction buttons.
REQ-007 i_Start_Btn  input  1  raw, asynchronous, active-high start button.
REQ-008 i_Move_Enable  input  1  high while the game is in PLAY; low suppresses direction pulses.
REQ-009 o_Up_Mvt, o_Down_Mvt, o_Left_Mvt, o_Right_Mvt  output  1 each  registered one-cycle move pulses for the frogger controller.
REQ-010 o_Game_Start  output  1  registered one-cycle start pulse.
REQ-011 o_Btn_State  output  5  debounced levels {Start, Right, Left, Down, Up}, bit 0 = Up.

Function
REQ-012 Each raw input SHALL pass through a 2-flop synchronizer before any other logic.
REQ-013 Each button SHALL have its own debounce counter: increments while the synchronized level differs from the debounced level, clears to 0 when they match.
REQ-014 When the counter reaches c_DEBOUNCE_LIMIT-1 and the levels still differ, the debounced level SHALL toggle and the counter clear (toggle after exactly c_DEBOUNCE_LIMIT differing cycles).
REQ-015 Counter width SHALL be $clog2(c_DEBOUNCE_LIMIT) minimum; the counter SHALL never wrap.
REQ-016 A debounced rising edge of Start SHALL produce o_Game_Start high for exactly one cycle, the cycle after the edge, regardless of i_Move_Enable; no auto-repeat.
REQ-017 At most one direction output SHALL be high in any cycle.
REQ-018 Simultaneous debounced direction rising edges SHALL resolve with priority Up > Down > Left > Right; losing edges are discarded, not queued.
REQ-019 Repeat FSM states: IDLE, DELAY, REPEAT; a register r_Dir holds the tracked direction.
REQ-020 IDLE: on a winning direction rising edge with i_Move_Enable high -> pulse that direction next cycle, load r_Dir, clear repeat counter, go DELAY.
REQ-021 DELAY: when the repeat counter reaches c_REPEAT_DELAY-1 with r_Dir still held -> pulse r_Dir, clear counter, go REPEAT.
REQ-022 REPEAT: when the counter reaches c_REPEAT_PERIOD-1 with r_Dir still held -> pulse r_Dir, clear counter, stay REPEAT.
REQ-023 In DELAY or REPEAT, a debounced rising edge of a different direction SHALL pulse that direction, replace r_Dir, clear counter, go DELAY.
REQ-024 In DELAY or REPEAT, debounced release of r_Dir SHALL return to IDLE next cycle with no pulse.
REQ-025 i_Move_Enable low in any state SHALL force IDLE and suppress direction pulses that cycle; a button still held when enable rises SHALL NOT pulse until released and re-pressed.
REQ-026 Latency raw press -> direction pulse SHALL be exactly c_DEBOUNCE_LIMIT+3 clock edges for a clean (bounce-free) press.

Reset
REQ-027 While i_Rst_L is low at a clock edge: all outputs 0, synchronizers 0, debounced levels 0, all counters 0, r_Dir 0, FSM IDLE.
REQ-028 Reset mid-operation SHALL abort any pending repeat with no pulse in the cycle after the reset edge.
REQ-029 A button held across reset release SHALL be treated as a new press (pulse after c_DEBOUNCE_LIMIT+3 edges).

Verification (parameters 4 / 10 / 6)
REQ-030 Clean Up press held 3 cycles, enable high -> no pulse; held 20 cycles -> o_Up_Mvt high for 1 cycle at edge 7 after press.
REQ-031 Up bouncing 1,0,1,0 then stable high -> exactly one o_Up_Mvt pulse, 7 edges after last bounce.
REQ-032 Left held 40 cycles after its first pulse -> repeat pulses at +10, +16, +22, +28, +34 cycles after the first pulse; none after release.
REQ-033 Up and Right pressed same cycle -> only o_Up_Mvt pulses; Right ignored until re-pressed.
REQ-034 Start pressed with i_Move_Enable low -> o_Game_Start single pulse at edge 7; no direction pulses; holding Down while enable rises -> no pulse.
REQ-035 i_Rst_L low for 1 cycle during REPEAT -> all outputs 0 next cycle, FSM IDLE, no pulses until re-debounce of held button.
